// File: rtl/reconciled_key_reader_pkg.sv
// Shared reconciled-key parameters and reader FSM state encoding.
// Contents: BRAM geometry, frame size, default read latency and buffer depth,
// and the reader_state_t enum used by reconciled_key_reader.
package reconciled_key_reader_pkg;

    localparam int unsigned RECONCILED_KEY_ADDR_WIDTH = 15;
    localparam int unsigned RECONCILED_KEY_DATA_WIDTH = 64;
    localparam int unsigned RECONCILED_FRAME_WORDS    = 256;
    localparam int unsigned RECONCILED_RD_LATENCY     = 2;
    localparam int unsigned RECONCILED_FIFO_DEPTH     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } reader_state_t;

endpackage

// File: rtl/reconciled_key_reader_if.sv
// Reconciled-key output stream (valid/ready with last flag).
// Ports: m_key_data, m_key_valid, m_key_last driven by the master;
// m_key_ready driven by the slave (privacy-amplification input).
interface reconciled_key_reader_if
    import reconciled_key_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RECONCILED_KEY_DATA_WIDTH
) ();

    logic [DATA_WIDTH-1:0] m_key_data;
    logic                  m_key_valid;
    logic                  m_key_ready;
    logic                  m_key_last;

    modport master (
        output m_key_data,
        output m_key_valid,
        output m_key_last,
        input  m_key_ready
    );

    modport slave (
        input  m_key_data,
        input  m_key_valid,
        input  m_key_last,
        output m_key_ready
    );

endinterface

// File: rtl/reconciled_key_reader_key_out_fifo.sv
// key_out_fifo: synchronous first-word-fall-through FIFO with occupancy count.
// Ports: clk, rst (sync, active-high), wr_en/wr_data push, rd_en pop
// (ignored when empty), rd_data head word (zero when empty), valid (not empty),
// count (current occupancy, registered).
module key_out_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 64,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_rd_c;
    logic [CNT_W-1:0] count_next_c;

    // Wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        do_rd_c      = rd_en && valid;
        count_next_c = count + CNT_W'(wr_en) - CNT_W'(do_rd_c);
    end

    // Storage array; no reset needed, contents are qualified by count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and a registered not-empty flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_rd_c) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count_next_c;
            valid <= (count_next_c != '0);
        end
    end

    assign rd_data = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/reconciled_key_reader.sv
// Reads one reconciled-key frame from BRAM port B and streams it to PA.
// Ports: clk, rst (sync, active-high); start_frame/key_addr_index/
// verification_fail request; busy, frame_done, frame_dropped, start_overrun
// status; reconciledkey_* BRAM port B; key_if master stream (data/valid/last,
// ready). Failed-verification frames are dropped without touching the BRAM.
module reconciled_key_reader
    import reconciled_key_reader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = RECONCILED_KEY_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = RECONCILED_KEY_DATA_WIDTH,
    parameter int unsigned FRAME_WORDS = RECONCILED_FRAME_WORDS,
    parameter int unsigned RD_LATENCY  = RECONCILED_RD_LATENCY,
    parameter int unsigned FIFO_DEPTH  = RECONCILED_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_frame,
    input  logic                  key_addr_index,
    input  logic                  verification_fail,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_dropped,
    output logic                  start_overrun,
    output logic                  reconciledkey_clkb,
    output logic                  reconciledkey_enb,
    output logic [ADDR_WIDTH-1:0] reconciledkey_addrb,
    input  logic [DATA_WIDTH-1:0] reconciledkey_doutb,
    reconciled_key_reader_if.master key_if
);

    localparam int unsigned CNT_W = $clog2(FRAME_WORDS + 1);
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = $clog2(FIFO_DEPTH + RD_LATENCY + 2);
    localparam int unsigned OFS_W = ADDR_WIDTH - 1;

    reader_state_t         state;
    logic                  index_q;
    logic [CNT_W-1:0]      issue_cnt;
    logic [CNT_W-1:0]      out_cnt;
    logic [RD_LATENCY-1:0] pipe;
    logic [OCC_W-1:0]      fifo_count;
    logic                  fifo_valid;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  pop_c;
    logic                  credit_c;
    logic [SUM_W-1:0]      pending_c;

    assign reconciledkey_clkb = clk;

    // Credit: buffered words plus every read not yet landed (the enb register
    // and the latency pipe). A pop on this edge frees a slot, so it is
    // subtracted; that keeps one word per cycle with ready high while the
    // total never exceeds FIFO_DEPTH.
    always_comb begin
        pop_c     = fifo_valid && key_if.m_key_ready;
        pending_c = SUM_W'(fifo_count) + SUM_W'(reconciledkey_enb);
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            pending_c = pending_c + SUM_W'(pipe[i]);
        end
        credit_c = (pending_c - SUM_W'(pop_c)) < SUM_W'(FIFO_DEPTH);
    end

    // In-flight tracker aligned with the BRAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= reconciledkey_enb;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    key_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (pipe[RD_LATENCY-1]),
        .wr_data (reconciledkey_doutb),
        .rd_en   (key_if.m_key_ready),
        .rd_data (fifo_data),
        .valid   (fifo_valid),
        .count   (fifo_count)
    );

    // Reader FSM, read issue and output counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            busy                <= 1'b0;
            frame_done          <= 1'b0;
            frame_dropped       <= 1'b0;
            start_overrun       <= 1'b0;
            reconciledkey_enb   <= 1'b0;
            reconciledkey_addrb <= '0;
            index_q             <= 1'b0;
            issue_cnt           <= '0;
            out_cnt             <= '0;
        end else begin
            frame_done        <= 1'b0;
            frame_dropped     <= 1'b0;
            start_overrun     <= 1'b0;
            reconciledkey_enb <= 1'b0;
            if (pop_c) begin
                out_cnt <= out_cnt + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (start_frame) begin
                        if (verification_fail) begin
                            frame_dropped <= 1'b1;
                        end else begin
                            // Buffer is empty here, so word 0 issues at once.
                            index_q             <= key_addr_index;
                            busy                <= 1'b1;
                            reconciledkey_enb   <= 1'b1;
                            reconciledkey_addrb <= {key_addr_index, OFS_W'(0)};
                            issue_cnt           <= CNT_W'(1);
                            out_cnt             <= '0;
                            state               <= (FRAME_WORDS > 1) ? READ : DRAIN;
                        end
                    end
                end
                READ: begin
                    if (start_frame) begin
                        start_overrun <= 1'b1;
                    end
                    if (credit_c) begin
                        reconciledkey_enb   <= 1'b1;
                        reconciledkey_addrb <= {index_q, OFS_W'(issue_cnt)};
                        issue_cnt           <= issue_cnt + CNT_W'(1);
                        if (issue_cnt == CNT_W'(FRAME_WORDS - 1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (start_frame) begin
                        start_overrun <= 1'b1;
                    end
                    if (pop_c && (out_cnt == CNT_W'(FRAME_WORDS - 1))) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign key_if.m_key_valid = fifo_valid;
    assign key_if.m_key_data  = fifo_data;
    assign key_if.m_key_last  = fifo_valid && (out_cnt == CNT_W'(FRAME_WORDS - 1));

endmodule

// File: tb/tb_reconciled_key_reader.sv
// Bench for reconciled_key_reader: BRAM model with two-cycle read latency,
// scoreboard queues for expected read addresses and stream words.
module tb_reconciled_key_reader;

    localparam int unsigned AW = 15;
    localparam int unsigned DW = 64;
    localparam int unsigned FW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_frame = 1'b0;
    logic          key_addr_index = 1'b0;
    logic          verification_fail = 1'b0;
    logic          busy, frame_done, frame_dropped, start_overrun;
    logic          clkb, enb;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb = '0;
    logic [DW-1:0] bram_s1 = '0;

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;
    int hs_cnt = 0;
    int occ_max = 0;
    int ready_mode = 0;

    logic [DW:0]   exp_data [$];
    logic [AW-1:0] exp_addr [$];
    logic [DW:0]   held;
    logic          held_valid = 1'b0;
    logic [DW:0]   e_word;
    logic [AW-1:0] e_addr;

    reconciled_key_reader_if #(.DATA_WIDTH(DW)) key_if ();

    reconciled_key_reader dut (
        .clk                 (clk),
        .rst                 (rst),
        .start_frame         (start_frame),
        .key_addr_index      (key_addr_index),
        .verification_fail   (verification_fail),
        .busy                (busy),
        .frame_done          (frame_done),
        .frame_dropped       (frame_dropped),
        .start_overrun       (start_overrun),
        .reconciledkey_clkb  (clkb),
        .reconciledkey_enb   (enb),
        .reconciledkey_addrb (addrb),
        .reconciledkey_doutb (doutb),
        .key_if              (key_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    function automatic logic [DW-1:0] bram_word(input logic [AW-1:0] a);
        return DW'(a) + DW'(16'hA5A5);
    endfunction

    // BRAM port B: two register stages between enb and doutb.
    always @(posedge clk) begin
        if (enb) bram_s1 <= bram_word(addrb);
        doutb <= bram_s1;
    end

    initial key_if.m_key_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       key_if.m_key_ready = 1'b1;
            1:       key_if.m_key_ready = (edge_cnt % 3 == 0);
            default: key_if.m_key_ready = 1'b0;
        endcase
    end

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            held_valid = 1'b0;
        end else begin
            if (int'(dut.fifo_count) > occ_max) occ_max = int'(dut.fifo_count);
            if (enb) begin
                checks++;
                if (exp_addr.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_enb got addr=%h want no read", addrb);
                end else begin
                    e_addr = exp_addr.pop_front();
                    if (addrb !== e_addr) begin
                        failures++;
                        $display("FAIL read_addr got=%h want=%h", addrb, e_addr);
                    end
                end
            end
            if (held_valid) begin
                checks++;
                if (!key_if.m_key_valid || {key_if.m_key_last, key_if.m_key_data} !== held) begin
                    failures++;
                    $display("FAIL stall_stable got v=%0b %h want v=1 %h", key_if.m_key_valid,
                             {key_if.m_key_last, key_if.m_key_data}, held);
                end
            end
            held_valid = 1'b0;
            if (key_if.m_key_valid) begin
                if (key_if.m_key_ready) begin
                    hs_cnt++;
                    checks++;
                    if (exp_data.size() == 0) begin
                        failures++;
                        $display("FAIL extra_word got=%h want none", key_if.m_key_data);
                    end else begin
                        e_word = exp_data.pop_front();
                        if ({key_if.m_key_last, key_if.m_key_data} !== e_word) begin
                            failures++;
                            $display("FAIL word got last=%0b data=%h want last=%0b data=%h",
                                     key_if.m_key_last, key_if.m_key_data, e_word[DW], e_word[DW-1:0]);
                        end
                    end
                end else begin
                    held_valid = 1'b1;
                    held = {key_if.m_key_last, key_if.m_key_data};
                end
            end
        end
    end

    task automatic push_frame(input logic idx);
        for (int i = 0; i < int'(FW); i++) begin
            e_addr = {idx, 14'(i)};
            exp_addr.push_back(e_addr);
            exp_data.push_back({(i == int'(FW) - 1), bram_word(e_addr)});
        end
    endtask

    // Pulse start_frame; returns just after the sampling edge (edge 0).
    task automatic do_start(input logic idx, input logic fail);
        @(posedge clk); #1;
        key_addr_index = idx;
        verification_fail = fail;
        start_frame = 1'b1;
        if (!fail) push_frame(idx);
        @(posedge clk); #1;
        start_frame = 1'b0;
        verification_fail = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, frame_done, frame_dropped, start_overrun, enb, key_if.m_key_valid, key_if.m_key_last} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=0000000",
                     {busy, frame_done, frame_dropped, start_overrun, enb, key_if.m_key_valid, key_if.m_key_last});
        end
        checks++;
        if (addrb !== '0) begin failures++; $display("FAIL reset_addrb got=%h want=0", addrb); end
        checks++;
        if (key_if.m_key_data !== '0) begin failures++; $display("FAIL reset_data got=%h want=0", key_if.m_key_data); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_frame(input logic idx);
        int done_cyc = -1, valid_cyc = -1;
        logic busy1 = 1'b0, enb1 = 1'b0, busy_done = 1'b1;
        ready_mode = 0;
        hs_cnt = 0;
        do_start(idx, 1'b0);
        for (int c = 1; c <= 1000 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin busy1 = busy; enb1 = enb; end
            if (key_if.m_key_valid && valid_cyc < 0) valid_cyc = c;
            if (frame_done) begin done_cyc = c; busy_done = busy; end
        end
        checks++;
        if ({busy1, enb1} !== 2'b11) begin failures++; $display("FAIL frame%0d_cycle1 busy/enb got=%b want=11", idx, {busy1, enb1}); end
        checks++;
        if (valid_cyc != 4) begin failures++; $display("FAIL frame%0d_first_valid got=%0d want=4", idx, valid_cyc); end
        checks++;
        if (done_cyc != 260) begin failures++; $display("FAIL frame%0d_done_cycle got=%0d want=260", idx, done_cyc); end
        checks++;
        if (busy_done !== 1'b0) begin failures++; $display("FAIL frame%0d_busy_at_done got=%b want=0", idx, busy_done); end
        checks++;
        if (hs_cnt != int'(FW) || exp_data.size() != 0 || exp_addr.size() != 0) begin
            failures++;
            $display("FAIL frame%0d_count got=%0d left=%0d/%0d want=256 left=0/0", idx, hs_cnt, exp_data.size(), exp_addr.size());
        end
    endtask

    task automatic test_backpressure();
        int done_cyc = -1;
        ready_mode = 1;
        hs_cnt = 0;
        occ_max = 0;
        do_start(1'b0, 1'b0);
        for (int c = 1; c <= 2000 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (frame_done) done_cyc = c;
        end
        checks++;
        if (done_cyc < 0) begin failures++; $display("FAIL bp_done got=timeout want=frame_done"); end
        checks++;
        if (hs_cnt != int'(FW) || exp_data.size() != 0) begin
            failures++; $display("FAIL bp_count got=%0d left=%0d want=256 left=0", hs_cnt, exp_data.size());
        end
        checks++;
        if (occ_max > 4) begin failures++; $display("FAIL bp_occupancy got=%0d want<=4", occ_max); end
        ready_mode = 0;
    endtask

    task automatic test_drop();
        logic d1 = 1'b0, d2 = 1'b1, any_enb = 1'b0, any_busy = 1'b0;
        do_start(1'b0, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) d1 = frame_dropped;
            if (c == 2) d2 = frame_dropped;
            if (enb) any_enb = 1'b1;
            if (busy) any_busy = 1'b1;
        end
        checks++;
        if ({d1, d2} !== 2'b10) begin failures++; $display("FAIL drop_pulse got=%b want=10", {d1, d2}); end
        checks++;
        if ({any_enb, any_busy} !== 2'b00) begin failures++; $display("FAIL drop_quiet enb/busy got=%b want=00", {any_enb, any_busy}); end
    endtask

    task automatic test_overrun();
        int done_cyc = -1;
        logic ov51 = 1'b0, ov52 = 1'b1;
        ready_mode = 0;
        hs_cnt = 0;
        do_start(1'b0, 1'b0);
        for (int c = 1; c <= 1000 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 51) ov51 = start_overrun;
            if (c == 52) ov52 = start_overrun;
            if (frame_done) done_cyc = c;
            if (c == 50) begin key_addr_index = 1'b1; start_frame = 1'b1; end
            if (c == 51) start_frame = 1'b0;
        end
        checks++;
        if ({ov51, ov52} !== 2'b10) begin failures++; $display("FAIL overrun_pulse got=%b want=10", {ov51, ov52}); end
        checks++;
        if (done_cyc != 260 || hs_cnt != int'(FW) || exp_data.size() != 0 || exp_addr.size() != 0) begin
            failures++;
            $display("FAIL overrun_frame done=%0d words=%0d left=%0d want done=260 words=256 left=0", done_cyc, hs_cnt, exp_data.size());
        end
    endtask

    task automatic test_reset_midframe();
        int done_cyc = -1;
        logic saw_done = 1'b0, late = 1'b0;
        ready_mode = 2;
        do_start(1'b0, 1'b0);
        for (int c = 1; c < 100; c++) begin
            @(negedge clk);
            if (frame_done) saw_done = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, frame_done, frame_dropped, start_overrun, enb, key_if.m_key_valid, key_if.m_key_last} !== 7'b0
            || addrb !== '0 || key_if.m_key_data !== '0) begin
            failures++;
            $display("FAIL midreset_state flags=%b addr=%h data=%h want all 0",
                     {busy, frame_done, frame_dropped, start_overrun, enb, key_if.m_key_valid, key_if.m_key_last},
                     addrb, key_if.m_key_data);
        end
        exp_data.delete();
        exp_addr.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (enb || key_if.m_key_valid || busy) late = 1'b1;
            if (frame_done) saw_done = 1'b1;
        end
        checks++;
        if ({saw_done, late} !== 2'b00) begin failures++; $display("FAIL midreset_quiet done/late got=%b want=00", {saw_done, late}); end
        ready_mode = 0;
        hs_cnt = 0;
        do_start(1'b0, 1'b0);
        for (int c = 1; c <= 1000 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (frame_done) done_cyc = c;
        end
        checks++;
        if (done_cyc != 260 || hs_cnt != int'(FW) || exp_data.size() != 0) begin
            failures++;
            $display("FAIL midreset_refill done=%0d words=%0d left=%0d want done=260 words=256 left=0", done_cyc, hs_cnt, exp_data.size());
        end
    endtask

    task automatic test_back_to_back();
        int done_a = -1, done_b = -1;
        logic b_busy1 = 1'b0, b_ov = 1'b0;
        ready_mode = 0;
        hs_cnt = 0;
        do_start(1'b0, 1'b0);
        for (int c = 1; c <= 1000 && done_a < 0; c++) begin
            @(negedge clk);
            if (frame_done) done_a = c;
        end
        key_addr_index = 1'b1;
        start_frame = 1'b1;
        push_frame(1'b1);
        @(posedge clk); #1;
        start_frame = 1'b0;
        for (int c = 1; c <= 1000 && done_b < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin b_busy1 = busy; b_ov = start_overrun; end
            if (frame_done) done_b = c;
        end
        checks++;
        if (done_a != 260) begin failures++; $display("FAIL b2b_first_done got=%0d want=260", done_a); end
        checks++;
        if ({b_busy1, b_ov} !== 2'b10) begin failures++; $display("FAIL b2b_accept busy/overrun got=%b want=10", {b_busy1, b_ov}); end
        checks++;
        if (done_b != 260 || hs_cnt != 2 * int'(FW) || exp_data.size() != 0 || exp_addr.size() != 0) begin
            failures++;
            $display("FAIL b2b_second done=%0d words=%0d left=%0d want done=260 words=512 left=0", done_b, hs_cnt, exp_data.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_frame(1'b0);
        test_single_frame(1'b1);
        test_backpressure();
        test_drop();
        test_overrun();
        test_reset_midframe();
        test_back_to_back();
        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
